// File: rtl/cache_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_arbiter_if
// Bundles the requester-side (I and D) and memory-side (pmem) signals of the
// cacheline arbiter.
//   master : the arbiter's view. It receives requests and pmem responses and
//            drives the responses, the pmem request and arbiter_idle.
//   slave  : the environment's view (requesters plus cacheline adaptor).
// Parameter S_LINE is the cacheline width in bits.
// ---------------------------------------------------------------------------
interface cache_arbiter_if #(
    parameter int S_LINE = 256
);
    // instruction side
    logic [31:0]       i_address;
    logic              i_read;
    logic [S_LINE-1:0] i_rdata;
    logic              i_resp;
    // data side
    logic [31:0]       d_address;
    logic              d_read;
    logic              d_write;
    logic [S_LINE-1:0] d_wdata;
    logic [S_LINE-1:0] d_rdata;
    logic              d_resp;
    // memory side
    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;
    // prefetch hint
    logic              arbiter_idle;

    modport master (
        input  i_address, i_read, d_address, d_read, d_write, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_address, pmem_read, pmem_write, pmem_wdata, arbiter_idle
    );

    modport slave (
        output i_address, i_read, d_address, d_read, d_write, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_address, pmem_read, pmem_write, pmem_wdata, arbiter_idle
    );
endinterface

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Shares one cacheline memory port between the instruction fetch path and
// the data cache. Each request is granted once, latched, and carried to the
// adaptor. The adaptor's completion is returned to the granted side in the
// same cycle. Under contention the grant alternates between the two sides.
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cache_arbiter_if.master, which carries
//            i_*    instruction-side read requests and responses
//            d_*    data-side read/writeback requests and responses
//            pmem_* line-aligned memory requests and responses
//            arbiter_idle  high when nothing is in flight or requested
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int S_OFFSET = 5,
    parameter int S_LINE   = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic        GRANT_I   = 1'b0;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       addr_q, addr_d;
    logic              write_q, write_d;
    logic [S_LINE-1:0] wdata_q, wdata_d;

    logic              d_req;
    logic              grant_to_d;
    logic              serving;

    assign d_req = bus.d_read | bus.d_write;

    // State register. Reset is asynchronous, so the pmem strobes (decoded
    // from state_q) fall as soon as rst_n goes low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state logic. The request is captured only at grant time, so
    // requester changes during service cannot affect the memory request.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        grant_to_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_read || d_req) begin
                    // On contention, the side that was not granted last wins.
                    if (bus.i_read && d_req)
                        grant_to_d = (last_grant_q == GRANT_I);
                    else
                        grant_to_d = d_req;
                    last_grant_d = grant_to_d;
                    state_d      = grant_to_d ? SERVE_D : SERVE_I;
                    addr_d       = (grant_to_d ? bus.d_address : bus.i_address) & LINE_MASK;
                    // A read and a write asserted together are treated as a write.
                    write_d      = grant_to_d & bus.d_write;
                    wdata_d      = grant_to_d ? bus.d_wdata : '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. The response and read data pass through combinationally, so
    // the arbiter adds no latency to the adaptor's completion.
    always_comb begin
        serving          = (state_q == SERVE_I) || (state_q == SERVE_D);
        bus.pmem_read    = serving & ~write_q;
        bus.pmem_write   = serving & write_q;
        bus.pmem_address = serving ? addr_q : '0;
        bus.pmem_wdata   = serving ? wdata_q : '0;
        bus.i_resp       = (state_q == SERVE_I) & bus.pmem_resp;
        bus.d_resp       = (state_q == SERVE_D) & bus.pmem_resp;
        bus.i_rdata      = bus.i_resp ? bus.pmem_rdata : '0;
        bus.d_rdata      = (bus.d_resp & ~write_q) ? bus.pmem_rdata : '0;
        bus.arbiter_idle = (state_q == IDLE) & ~bus.i_read & ~d_req;
    end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates between the instruction-side requester (next-line prefetcher output port) and the data cache for a single 256-bit cacheline memory port, and is the responder to both. Sits between the two L1 paths and the cacheline adaptor. It also drives `arbiter_idle`, which tells the prefetcher when a speculative line fetch will not delay demand traffic.

## Interface
- `s_offset`, 5, log2 of line size in bytes; low `s_offset` address bits are zeroed toward memory
- `s_line`, 256, line width in bits

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `i_address`  in  32  instruction-side line address
- `i_read`  in  1  instruction-side read request, held until `i_resp`
- `i_rdata`  out  256  instruction-side read data, valid with `i_resp`
- `i_resp`  out  1  instruction-side completion, one cycle
- `d_address`  in  32  data-side line address
- `d_read`  in  1  data-side read request, held until `d_resp`
- `d_write`  in  1  data-side writeback request, held until `d_resp`
- `d_wdata`  in  256  writeback data
- `d_rdata`  out  256  data-side read data, valid with `d_resp`
- `d_resp`  out  1  data-side completion, one cycle
- `pmem_address`  out  32  line-aligned address to adaptor
- `pmem_read`  out  1  memory read, held until `pmem_resp`
- `pmem_write`  out  1  memory write, held until `pmem_resp`
- `pmem_wdata`  out  256  write data to adaptor
- `pmem_rdata`  in  256  read data from adaptor
- `pmem_resp`  in  1  adaptor completion, one cycle
- `arbiter_idle`  out  1  no transaction in flight or pending

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE: `d_req = d_read | d_write`. Only `i_read` -> SERVE_I; only `d_req` -> SERVE_D; both -> side not in `last_grant`. Grant latches address (low `s_offset` bits zeroed), op type, and `d_wdata` into registers; `last_grant` updated.
- `last_grant` resets to I, so first contention goes to D.
- SERVE_I/SERVE_D: `pmem_address` from latched address; `pmem_read` or `pmem_write` from latched op; `pmem_wdata` from latched data. Requester input changes mid-transaction are ignored.
- On `pmem_resp`: granted side's `*_resp` = 1 same cycle; `*_rdata` = `pmem_rdata` combinationally (0 for write). Next state DONE.
- DONE: one cycle, no grant, no memory request, all responses 0; -> IDLE. Guarantees requesters have dropped their request before re-arbitration.
- `d_read` and `d_write` both high: illegal; treated as write.
- `arbiter_idle` = (state == IDLE) & ~i_read & ~d_req. Combinational.
- Non-granted side: `*_resp` = 0, `*_rdata` = 0 at all times.

## Timing
- Reset (async assert, any state): state IDLE, `last_grant` = I, latched regs 0. All outputs 0 except `arbiter_idle` = 1 when inputs idle. `pmem_read`/`pmem_write` fall immediately, without waiting for a clock. An in-flight adaptor response after reset is ignored.
- Request seen in IDLE at cycle t -> `pmem_*` asserted from t+1.
- `pmem_resp` at cycle t+k -> `*_resp` in t+k (zero added response latency), DONE at t+k+1, IDLE at t+k+2.
- Minimum occupancy per transaction: 3 cycles plus memory latency. Back-to-back requests from the same side cost 2 idle cycles.
- `pmem_resp` asserted outside SERVE_*: ignored, no state change.
- A request arriving during SERVE_*/DONE waits. Under continuous contention, grants strictly alternate I, D, I, D.

## Test plan
- Reset then lone `i_read` at 0x0000_1234 -> `pmem_read` = 1, `pmem_address` = 0x0000_1220 next cycle. Adaptor returns line 0xAA.. after 4 cycles -> `i_resp` = 1, `i_rdata` = 0xAA.. that cycle. `d_resp` stays 0.
- `i_read` and `d_read` asserted in the same IDLE cycle after reset -> D served first, then I. Hold both continuously -> grant order D, I, D, I.
- `d_write` 0x8000_0040 with wdata pattern P; change `d_wdata` and `d_address` mid-transaction -> `pmem_wdata` = P and `pmem_address` = 0x8000_0040 throughout; `d_resp` on `pmem_resp`; `d_rdata` = 0.
- `arbiter_idle` check: 1 in idle; 0 in the same cycle any request rises; 0 through SERVE and DONE; 1 again in IDLE with no requests.
- Deassert `rst_n` mid SERVE_D between clock edges -> `pmem_write` = 0 immediately. After release, a stray `pmem_resp` produces no `*_resp`; the next `i_read` is served normally.
- Spurious `pmem_resp` in IDLE, and `d_read` with `d_write` together -> no response for the spurious pulse; the dual request issues `pmem_write` only.
